fsm_pattern_detector: RTL and testbench

//  Parametrised, run-time programmable sequence-detector FSM; next generation of our fixed 3-switch FSM.

---
 rtl/fsm_pattern_detector.sv | 165 ++++++++++++++++
 tb/tb_fsm_pattern_detector.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_detector.sv
// fsm_pattern_detector
//   Run-time programmable sequence detector. Compares a stream of SW_W-bit
//   symbols, one per sw_valid strobe, against a stored pattern of up to
//   DEPTH symbols. Emits a one-cycle match pulse, the current match progress
//   and a saturating match counter.
//
//   Optional feature macro: FSM_TIMEOUT_EN
//     defined   -> a partial match is abandoned after TIMEOUT_CYC idle cycles
//                  with a one-cycle timeout pulse
//     undefined -> no timer, timeout tied low, partial matches held forever
//
// Ports
//   clk         rising-edge clock
//   btnC        synchronous active-high reset
//   sw          input symbol, consumed when sw_valid=1
//   sw_valid    symbol strobe
//   cfg_we      write cfg_sym into pattern[cfg_idx]
//   cfg_idx     pattern slot index
//   cfg_sym     pattern symbol
//   cfg_len_we  write pattern length (clamped to 1..DEPTH)
//   cfg_len     pattern length
//   match       one-cycle pulse, full pattern just completed
//   progress    symbols currently matched (0..len-1)
//   match_cnt   matches since reset, saturating
//   busy        progress != 0
//   timeout     one-cycle pulse, partial match abandoned
module fsm_pattern_detector #(
  parameter int SW_W        = 3,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 4,
  parameter int OVERLAP     = 1,
  parameter int TIMEOUT_CYC = 1000,
  localparam int IDXW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             btnC,
  input  logic [SW_W-1:0]  sw,
  input  logic             sw_valid,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [SW_W-1:0]  cfg_sym,
  input  logic             cfg_len_we,
  input  logic [IDXW:0]    cfg_len,
  output logic             match,
  output logic [IDXW:0]    progress,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             timeout
);

  localparam logic [IDXW:0] LEN_MAX = (IDXW+1)'(DEPTH);
  localparam logic [IDXW:0] ONE     = (IDXW+1)'(1);

  // The FSM state is progress itself (IDLE: 0, TRACK: 0<p<len); the MATCH
  // state is the registered match pulse.
  logic [DEPTH-1:0][SW_W-1:0] pattern_q, pattern_d;
  logic [IDXW:0]              len_q, len_d;
  logic [IDXW:0]              prog_q, prog_d;
  logic                       match_q, match_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

`ifdef FSM_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMW-1:0] TIMER_LAST = TMW'(TIMEOUT_CYC - 1);
  logic [TMW-1:0] timer_q, timer_d;
  logic           to_q, to_d;
`endif

  logic          cfg_wr, hit, first;
  logic [IDXW:0] prog_inc, len_clamp;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (btnC) begin
      pattern_q <= '0;
      len_q     <= LEN_MAX;
      prog_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
`ifdef FSM_TIMEOUT_EN
      timer_q   <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      prog_q    <= prog_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
`ifdef FSM_TIMEOUT_EN
      timer_q   <= timer_d;
      to_q      <= to_d;
`endif
    end
  end

  // ---------------- next state ----------------
  assign cfg_wr    = cfg_we | cfg_len_we;
  assign hit       = (sw == pattern_q[prog_q[IDXW-1:0]]);
  assign first     = (sw == pattern_q[0]);
  assign prog_inc  = prog_q + ONE;
  assign len_clamp = (cfg_len == '0)     ? ONE     :
                     (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    prog_d    = prog_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;
`ifdef FSM_TIMEOUT_EN
    timer_d   = timer_q;
    to_d      = 1'b0;
`endif
    if (cfg_wr) begin
      // Config write wins; a symbol arriving this cycle is dropped.
      if (cfg_we)     pattern_d[cfg_idx] = cfg_sym;
      if (cfg_len_we) len_d = len_clamp;
      prog_d = '0;
`ifdef FSM_TIMEOUT_EN
      timer_d = '0;
`endif
    end else if (sw_valid) begin
`ifdef FSM_TIMEOUT_EN
      timer_d = '0;
`endif
      if (hit && prog_inc == len_q) begin
        match_d = 1'b1;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // Overlap only restarts on the first pattern symbol, not full KMP.
        prog_d  = (OVERLAP != 0 && len_q != ONE && first) ? ONE : '0;
      end else if (hit) begin
        prog_d = prog_inc;
      end else begin
        prog_d = first ? ONE : '0;
      end
    end else begin
`ifdef FSM_TIMEOUT_EN
      if (prog_q != '0) begin
        if (timer_q == TIMER_LAST) begin
          prog_d  = '0;
          to_d    = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    match     = match_q;
    progress  = prog_q;
    match_cnt = cnt_q;
    busy      = (prog_q != '0);
`ifdef FSM_TIMEOUT_EN
    timeout   = to_q;
`else
    timeout   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fsm_pattern_detector.sv
module tb_fsm_pattern_detector;

  localparam int TO_CYC = 10;

  logic       clk = 1'b0;
  logic       btnC, sw_valid, cfg_we, cfg_len_we;
  logic [2:0] sw, cfg_sym, cfg_idx;
  logic [3:0] cfg_len;

  logic       match_a, busy_a, to_a, match_b, busy_b, to_b;
  logic [3:0] prog_a, cnt_a, prog_b, cnt_b;

  always #5 clk = ~clk;

  // a: overlapping matches, b: restart after match
  fsm_pattern_detector #(.SW_W(3), .DEPTH(8), .CNT_W(4), .OVERLAP(1), .TIMEOUT_CYC(TO_CYC)) dut_a (
    .clk(clk), .btnC(btnC), .sw(sw), .sw_valid(sw_valid), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sym(cfg_sym), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .match(match_a),
    .progress(prog_a), .match_cnt(cnt_a), .busy(busy_a), .timeout(to_a));

  fsm_pattern_detector #(.SW_W(3), .DEPTH(8), .CNT_W(4), .OVERLAP(0), .TIMEOUT_CYC(TO_CYC)) dut_b (
    .clk(clk), .btnC(btnC), .sw(sw), .sw_valid(sw_valid), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sym(cfg_sym), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .match(match_b),
    .progress(prog_b), .match_cnt(cnt_b), .busy(busy_b), .timeout(to_b));

  int checks = 0;
  int errors = 0;

  // reference model, index 0 -> overlap, 1 -> no overlap
  int m_pat [8];
  int m_len;
  int m_prog [2];
  int m_cnt [2];
  int m_timer [2];
  bit m_match [2];
  bit m_to [2];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input int s, input bit we,
                            input int idx, input int sym, input bit lwe, input int l);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_pat[i] = 0;
      m_len = 8;
      for (int k = 0; k < 2; k++) begin
        m_prog[k] = 0; m_cnt[k] = 0; m_timer[k] = 0; m_match[k] = 0; m_to[k] = 0;
      end
    end else if (we || lwe) begin
      if (we) m_pat[idx] = sym;
      if (lwe) m_len = (l == 0) ? 1 : (l > 8 ? 8 : l);
      for (int k = 0; k < 2; k++) begin
        m_prog[k] = 0; m_timer[k] = 0; m_match[k] = 0; m_to[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_match[k] = 0;
        m_to[k] = 0;
        if (v) begin
          m_timer[k] = 0;
          if (s == m_pat[m_prog[k]]) begin
            if (m_prog[k] + 1 == m_len) begin
              m_match[k] = 1;
              if (m_cnt[k] < 15) m_cnt[k]++;
              m_prog[k] = (k == 0 && m_len > 1 && s == m_pat[0]) ? 1 : 0;
            end else begin
              m_prog[k]++;
            end
          end else begin
            m_prog[k] = (s == m_pat[0]) ? 1 : 0;
          end
        end else begin
`ifdef FSM_TIMEOUT_EN
          if (m_prog[k] != 0) begin
            m_timer[k]++;
            if (m_timer[k] == TO_CYC) begin
              m_prog[k] = 0; m_to[k] = 1; m_timer[k] = 0;
            end
          end
`endif
        end
      end
    end
  endtask

  task automatic compare_all();
    check("match_ov",   match_a, m_match[0]);
    check("prog_ov",    prog_a,  m_prog[0]);
    check("cnt_ov",     cnt_a,   m_cnt[0]);
    check("busy_ov",    busy_a,  (m_prog[0] != 0) ? 1 : 0);
    check("timeout_ov", to_a,    m_to[0]);
    check("match_no",   match_b, m_match[1]);
    check("prog_no",    prog_b,  m_prog[1]);
    check("cnt_no",     cnt_b,   m_cnt[1]);
    check("busy_no",    busy_b,  (m_prog[1] != 0) ? 1 : 0);
    check("timeout_no", to_b,    m_to[1]);
  endtask

  // drive one cycle, advance the model, compare everything
  task automatic apply(input bit rst, input bit v, input int s, input bit we,
                       input int idx, input int sym, input bit lwe, input int l);
    btnC = rst; sw_valid = v; sw = 3'(s); cfg_we = we; cfg_idx = 3'(idx);
    cfg_sym = 3'(sym); cfg_len_we = lwe; cfg_len = 4'(l);
    @(posedge clk); #1;
    model_step(rst, v, s, we, idx, sym, lwe, l);
    compare_all();
  endtask

  task automatic feed(input int s);               apply(0, 1, s, 0, 0, 0, 0, 0); endtask
  task automatic idle();                          apply(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr_sym(input int i, input int s); apply(0, 0, 0, 1, i, s, 0, 0); endtask
  task automatic wr_len(input int l);              apply(0, 0, 0, 0, 0, 0, 1, l); endtask
  task automatic do_rst();                         apply(1, 0, 0, 0, 0, 0, 0, 0); endtask

  // op: 0 idle, 1 feed a, 2 write slot a = b, 3 write len a
  typedef struct {
    int op; int a; int b;
    bit m_ov; int p_ov; bit m_no; int p_no;
  } vec_t;

  vec_t tbl [$];

  initial begin
    btnC = 1; sw_valid = 0; sw = 0; cfg_we = 0; cfg_idx = 0; cfg_sym = 0; cfg_len_we = 0; cfg_len = 0;

    // reset state
    do_rst();
    check("rst_match", match_a, 0);
    check("rst_prog",  prog_a,  0);
    check("rst_cnt",   cnt_a,   0);
    check("rst_busy",  busy_a,  0);
    check("rst_to",    to_a,    0);

    // pattern {5,2,7}
    tbl.push_back('{2,0,5, 0,0,0,0}); tbl.push_back('{2,1,2, 0,0,0,0});
    tbl.push_back('{2,2,7, 0,0,0,0}); tbl.push_back('{3,3,0, 0,0,0,0});
    tbl.push_back('{1,5,0, 0,1,0,1}); tbl.push_back('{1,2,0, 0,2,0,2});
    tbl.push_back('{1,7,0, 1,0,1,0}); tbl.push_back('{0,0,0, 0,0,0,0});
    // pattern {1,1}: overlap vs restart
    tbl.push_back('{2,0,1, 0,0,0,0}); tbl.push_back('{2,1,1, 0,0,0,0});
    tbl.push_back('{3,2,0, 0,0,0,0});
    tbl.push_back('{1,1,0, 0,1,0,1}); tbl.push_back('{1,1,0, 1,1,1,0});
    tbl.push_back('{1,1,0, 1,1,0,1}); tbl.push_back('{0,0,0, 0,1,0,1});
    // pattern {3,4}: mismatch on a first-symbol restarts at 1
    tbl.push_back('{2,0,3, 0,0,0,0}); tbl.push_back('{2,1,4, 0,0,0,0});
    tbl.push_back('{1,3,0, 0,1,0,1}); tbl.push_back('{1,3,0, 0,1,0,1});
    tbl.push_back('{1,4,0, 1,0,1,0}); tbl.push_back('{1,3,0, 0,1,0,1});
    tbl.push_back('{1,6,0, 0,0,0,0});

    foreach (tbl[i]) begin
      case (tbl[i].op)
        0: idle();
        1: feed(tbl[i].a);
        2: wr_sym(tbl[i].a, tbl[i].b);
        default: wr_len(tbl[i].a);
      endcase
      check($sformatf("tbl%0d_match_ov", i), match_a, tbl[i].m_ov);
      check($sformatf("tbl%0d_prog_ov",  i), prog_a,  tbl[i].p_ov);
      check($sformatf("tbl%0d_match_no", i), match_b, tbl[i].m_no);
      check($sformatf("tbl%0d_prog_no",  i), prog_b,  tbl[i].p_no);
    end
    check("tbl_cnt_ov", cnt_a, 4);
    check("tbl_cnt_no", cnt_b, 3);

    // config write with a symbol in the same cycle: slot written, symbol dropped
    wr_sym(0, 5); wr_sym(1, 2); wr_sym(2, 7); wr_len(3);
    feed(5); feed(2);
    check("cfgcoll_pre_prog", prog_a, 2);
    apply(0, 1, 7, 1, 2, 6, 0, 0);
    check("cfgcoll_prog",  prog_a,  0);
    check("cfgcoll_match", match_a, 0);
    feed(5); feed(2); feed(6);
    check("cfgcoll_new_slot_match", match_a, 1);
    feed(5); feed(2); feed(7);
    check("cfgcoll_old_slot_match", match_a, 0);
    check("cfgcoll_old_slot_prog",  prog_a,  0);

    // length clamping: 0 -> 1, 15 -> 8
    wr_len(0); wr_sym(0, 4);
    feed(4);
    check("len0_match", match_a, 1);
    wr_len(15);
    feed(4); feed(2); feed(6); feed(0); feed(0); feed(0); feed(0);
    check("len15_prog", prog_a, 7);
    feed(0);
    check("len15_match", match_a, 1);

    // counter saturation, held sw_valid with len=1 pulses once per symbol
    do_rst();
    wr_len(1); wr_sym(0, 3);
    for (int i = 0; i < 17; i++) feed(3);
    check("sat_cnt_ov", cnt_a, 15);
    check("sat_cnt_no", cnt_b, 15);

    // reset mid-pattern wins over a valid symbol
    wr_len(3); wr_sym(0, 5); wr_sym(1, 2);
    feed(5);
    apply(1, 1, 2, 0, 0, 0, 0, 0);
    check("midrst_prog",  prog_a,  0);
    check("midrst_cnt",   cnt_a,   0);
    check("midrst_match", match_a, 0);
    check("midrst_busy",  busy_a,  0);

    // after reset: len=8, pattern all zero
    for (int i = 0; i < 7; i++) feed(0);
    check("rstpat_prog", prog_a, 7);
    feed(0);
    check("rstpat_match", match_a, 1);
    check("rstpat_cnt",   cnt_a,   1);

    // idle behaviour with a partial match
    wr_sym(0, 1); wr_sym(1, 2); wr_len(2);
    feed(1);
`ifdef FSM_TIMEOUT_EN
    for (int i = 0; i < TO_CYC - 1; i++) idle();
    check("to_pre_prog", prog_a, 1);
    check("to_pre_to",   to_a,   0);
    idle();
    check("to_pulse", to_a,   1);
    check("to_prog",  prog_a, 0);
    idle();
    check("to_pulse_end", to_a, 0);
    feed(1);
    for (int i = 0; i < TO_CYC - 1; i++) idle();
    feed(2);
    check("to_late_match", match_a, 1);
    check("to_late_to",    to_a,    0);
`else
    for (int i = 0; i < 2 * TO_CYC; i++) idle();
    check("hold_prog", prog_a, 1);
    check("hold_to",   to_a,   0);
`endif

    // randomized traffic against the model
    do_rst();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 1)       apply(1, $urandom_range(0, 1), $urandom_range(0, 3), 0, 0, 0, 0, 0);
      else if (r < 8)  apply(0, $urandom_range(0, 1), $urandom_range(0, 3), 1,
                             $urandom_range(0, 7), $urandom_range(0, 3), 0, 0);
      else if (r < 11) apply(0, $urandom_range(0, 1), $urandom_range(0, 3), 0, 0, 0, 1,
                             $urandom_range(0, 15));
      else if (r < 12) apply(0, 1, $urandom_range(0, 3), 1, $urandom_range(0, 7),
                             $urandom_range(0, 3), 1, $urandom_range(0, 5));
      else if (r < 140) feed($urandom_range(0, 3));
      else              idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
